// File: rtl/image_writer.sv
// image_writer: unpacks a raster-ordered R,G,B byte stream into one-cycle frame-buffer pixel writes.
// Optional running byte checksum enabled by defining IMAGE_WRITER_CHECKSUM_EN.
`default_nettype none

module image_writer #(
    parameter int IMAGE_WIDTH  = 48,
    parameter int IMAGE_HEIGHT = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       wr_en,
    output logic [9:0] wr_x,
    output logic [9:0] wr_y,
    output logic [7:0] wr_r,
    output logic [7:0] wr_g,
    output logic [7:0] wr_b,
    output logic       busy,
    output logic       done,
    output logic       abort,
    output logic [7:0] checksum
);

    localparam logic [9:0] X_LAST = 10'(IMAGE_WIDTH - 1);
    localparam logic [9:0] Y_LAST = 10'(IMAGE_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GET_R = 3'd1,
        S_GET_G = 3'd2,
        S_GET_B = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic [7:0] r_q, r_d, g_q, g_d;
    logic [9:0] wr_x_q, wr_x_d, wr_y_q, wr_y_d;
    logic [7:0] wr_r_q, wr_r_d, wr_g_q, wr_g_d, wr_b_q, wr_b_d;
    logic       in_ready_q, in_ready_d, wr_en_q, wr_en_d, busy_q, busy_d;
    logic       done_q, done_d, abort_q, abort_d;
    logic       accept;

    // A restart takes priority over a byte offered in the same cycle.
    assign accept = in_valid & in_ready_q & ~start;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        g_d     = g_q;
        wr_x_d  = wr_x_q;
        wr_y_d  = wr_y_q;
        wr_r_d  = wr_r_q;
        wr_g_d  = wr_g_q;
        wr_b_d  = wr_b_q;
        abort_d = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_GET_R;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            S_GET_R: if (accept) begin
                r_d     = in_data;
                state_d = S_GET_G;
            end
            S_GET_G: if (accept) begin
                g_d     = in_data;
                state_d = S_GET_B;
            end
            S_GET_B: if (accept) begin
                wr_x_d  = x_q;
                wr_y_d  = y_q;
                wr_r_d  = r_q;
                wr_g_d  = g_q;
                wr_b_d  = in_data;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_GET_R;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        y_d = y_q + 10'd1;
                    end
                end else begin
                    x_d = x_q + 10'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start && busy_q) begin
            state_d = S_GET_R;
            x_d     = '0;
            y_d     = '0;
            abort_d = 1'b1;
        end

        in_ready_d = (state_d == S_GET_R) || (state_d == S_GET_G) || (state_d == S_GET_B);
        busy_d     = in_ready_d || (state_d == S_WRITE);
        wr_en_d    = (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            r_q        <= '0;
            g_q        <= '0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
            wr_r_q     <= '0;
            wr_g_q     <= '0;
            wr_b_q     <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            r_q        <= r_d;
            g_q        <= g_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_r_q     <= wr_r_d;
            wr_g_q     <= wr_g_d;
            wr_b_q     <= wr_b_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

`ifdef IMAGE_WRITER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 8'd0;
`endif

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_x     = wr_x_q;
    assign wr_y     = wr_y_q;
    assign wr_r     = wr_r_q;
    assign wr_g     = wr_g_q;
    assign wr_b     = wr_b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign abort    = abort_q;

endmodule

`default_nettype wire

// File: doc/image_writer.md
IMAGE_WRITER -- requirements
Module: image_writer

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 48, meaning pixels per row.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 48, meaning rows per frame.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  begin a new frame load at pixel (0,0).
REQ-006 SHALL have port in_data  input  8  streamed colour byte, order R,G,B per pixel, raster order.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  byte accepted when in_valid and in_ready are both high on a rising edge.
REQ-009 SHALL have port wr_en  output  1  one-cycle frame-buffer write strobe.
REQ-010 SHALL have ports wr_x, wr_y  output  10 each  pixel coordinates in display coordinates.
REQ-011 SHALL have ports wr_r, wr_g, wr_b  output  8 each  pixel colour.
REQ-012 SHALL have port busy  output  1  high from start until the frame completes or aborts.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the last pixel write.
REQ-014 SHALL have port abort  output  1  one-cycle pulse when start arrives while busy.
REQ-015 SHALL have port checksum  output  8  running byte sum (see Configuration).

Function
REQ-016 SHALL implement states IDLE, GET_R, GET_G, GET_B, WRITE, DONE.
REQ-017 IDLE: in_ready=0, bytes ignored; start=1 -> GET_R, x=y=0, checksum=0.
REQ-018 GET_R/GET_G/GET_B: in_ready=1; on accept, latch byte into R/G/B register and advance to next state (GET_B -> WRITE).
REQ-019 GET_x with in_valid=0: hold state, no register change.
REQ-020 WRITE: in_ready=0, wr_en=1 for exactly one cycle, wr_x/wr_y/wr_r/wr_g/wr_b hold the pixel; latency from B-byte accept to wr_en is 1 cycle.
REQ-021 Minimum rate: 4 cycles per pixel with in_valid held high.
REQ-022 After WRITE: x increments; x=IMAGE_WIDTH-1 wraps to 0 and y increments; pixel (IMAGE_WIDTH-1, IMAGE_HEIGHT-1) -> DONE, else -> GET_R.
REQ-023 DONE: done=1 for one cycle, busy=0, then IDLE; wr_x/wr_y/colour outputs keep last values.
REQ-024 busy SHALL be 1 in GET_R, GET_G, GET_B, WRITE; 0 in IDLE and DONE.
REQ-025 start while busy: abort=1 next cycle, no wr_en for the partial pixel, x=y=0, checksum=0, state GET_R; abort and restart simultaneous.
REQ-026 start in DONE: treated as start from IDLE, done still pulses that cycle, no abort.
REQ-027 wr_en SHALL be 0 in every state except WRITE.
REQ-028 Coordinate counters are 10 bits; they never exceed IMAGE_WIDTH-1 / IMAGE_HEIGHT-1.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, x=y=0, colour registers 0, checksum 0.
REQ-030 During and after reset all outputs SHALL be 0: in_ready, wr_en, wr_x, wr_y, wr_r, wr_g, wr_b, busy, done, abort, checksum.
REQ-031 Reset mid-frame SHALL discard the partial frame without a done or abort pulse.

Configuration
REQ-032 With macro IMAGE_WRITER_CHECKSUM_EN defined, checksum SHALL be the modulo-256 sum of all bytes accepted since the last start, updated the cycle after each accept.
REQ-033 Without IMAGE_WRITER_CHECKSUM_EN, checksum SHALL be constant 0 and no adder SHALL be synthesised.

Verification
REQ-034 Reset, start, bytes 0x11,0x22,0x33 -> one cycle later wr_en=1, wr_x=0, wr_y=0, wr_r=0x11, wr_g=0x22, wr_b=0x33.
REQ-035 Full 48x48 frame with in_valid held high -> 2304 wr_en pulses 4 cycles apart, row wrap at wr_x=47, done once after write (47,47), busy=0.
REQ-036 in_valid toggled 0/1 every cycle -> identical write data/coordinates to REQ-035, pixel rate halved-or-slower, no dropped bytes.
REQ-037 start after 2 bytes of pixel 5 -> abort pulse, no wr_en for pixel 5, next write at (0,0).
REQ-038 rst asserted during GET_G -> all outputs 0 asynchronously, no done; fresh start then writes (0,0) correctly.
REQ-039 With IMAGE_WRITER_CHECKSUM_EN, bytes 0x80,0x90,0x10 -> checksum 0x20; without it checksum stays 0.
